// File: rtl/fc_output_arbiter_if.sv
// Bundle of requester-side and serializer-side signals for the FC output arbiter.
// The arbiter connects through the master modport, its environment through the slave modport.
interface fc_output_arbiter_if #(
    parameter int NUM_REQ      = 4,
    parameter int LAYER_HEIGHT = 5,
    parameter int WORD_SIZE    = 16
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                                 req_valid_i;
    logic [NUM_REQ-1:0]                                 req_ready_o;
    logic [NUM_REQ-1:0][LAYER_HEIGHT-1:0][WORD_SIZE-1:0] req_data_i;
    logic                                               ser_valid_o;
    logic                                               ser_ready_i;
    logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0]             ser_data_o;
    logic                                               ser_yumi_i;
    logic [ID_W-1:0]                                    src_id_o;
    logic                                               src_id_valid_o;
    logic                                               busy_o;

    modport master (
        input  req_valid_i, req_data_i, ser_ready_i, ser_yumi_i,
        output req_ready_o, ser_valid_o, ser_data_o, src_id_o, src_id_valid_o, busy_o
    );

    modport slave (
        output req_valid_i, req_data_i, ser_ready_i, ser_yumi_i,
        input  req_ready_o, ser_valid_o, ser_data_o, src_id_o, src_id_valid_o, busy_o
    );
endinterface

// File: rtl/fc_output_arbiter.sv
// Round-robin arbiter sharing one parallel-to-serial FC output stage among NUM_REQ layers;
// holds the grant until the serializer drains LAYER_HEIGHT words and tags them with the source ID.
module fc_output_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int LAYER_HEIGHT = 5,
    parameter int WORD_SIZE    = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    fc_output_arbiter_if.master  bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LAYER_HEIGHT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAYER_HEIGHT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]  last_q,  last_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic [ID_W-1:0]  pick_id;
    logic             pick_found;
    logic             in_load;
    logic             in_drain;
    logic             load_valid;

    // Outputs are forced low while reset is asserted so an aborted LOAD never accepts.
    assign in_load    = !reset_i && (state_q == S_LOAD);
    assign in_drain   = !reset_i && (state_q == S_DRAIN);
    assign load_valid = in_load && bus.req_valid_i[grant_q];

    always_comb begin : rr_pick
        logic [ID_W-1:0] cand;
        pick_id    = last_q;
        pick_found = 1'b0;
        cand       = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = ID_W'((int'(last_q) + off) % NUM_REQ);
            if (!pick_found && bus.req_valid_i[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_id;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_valid && bus.ser_ready_i) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.ser_yumi_i) begin
                    if (cnt_q == CNT_LAST) begin
                        last_d  = grant_q;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign bus.req_ready_o[gi] = in_load && (grant_q == ID_W'(gi))
                                     && bus.ser_ready_i && bus.req_valid_i[gi];
    end

    assign bus.ser_valid_o    = load_valid;
    assign bus.ser_data_o     = in_load ? bus.req_data_i[grant_q] : '0;
    assign bus.src_id_valid_o = in_drain;
    assign bus.src_id_o       = in_drain ? grant_q : '0;
    assign bus.busy_o         = !reset_i && (state_q != S_IDLE);
endmodule

// File: tb/tb_fc_output_arbiter.sv
// Directed bench for fc_output_arbiter: expected grant IDs are queued when requests are driven
// and popped as each vector is accepted and drained.
module tb_fc_output_arbiter;
    localparam int NR = 4;
    localparam int LH = 5;
    localparam int WS = 16;

    typedef logic [LH-1:0][WS-1:0] vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fc_output_arbiter_if #(.NUM_REQ(NR), .LAYER_HEIGHT(LH), .WORD_SIZE(WS)) bus ();

    fc_output_arbiter #(.NUM_REQ(NR), .LAYER_HEIGHT(LH), .WORD_SIZE(WS)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    logic [127:0] all_outs;
    assign all_outs = 128'({bus.ser_valid_o, bus.ser_data_o, bus.req_ready_o,
                            bus.src_id_o, bus.src_id_valid_o, bus.busy_o});

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Requester r word w carries r*16 + w + 1, so requester 0 offers {5,4,3,2,1}.
    function automatic vec_t vec(input int r);
        vec_t v;
        for (int w = 0; w < LH; w++) v[w] = WS'(r * 16 + w + 1);
        return v;
    endfunction

    task automatic serve_burst(input int stall, input bit gappy);
        int id;
        int guard;
        int n;
        bit y;
        logic [7:0] pat;
        pat = 8'b1101_1001;
        chk("sb_nonempty", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() == 0) return;
        id = exp_q.pop_front();
        guard = 0;
        while (bus.ser_valid_o !== 1'b1 && guard < 20) begin
            cyc();
            guard++;
        end
        chk("load_latency", 128'(guard), 128'(1));
        if (guard >= 20) return;
        for (int k = 0; k < stall; k++) begin
            bus.ser_ready_i = 1'b0;
            #1;
            chk("stall_valid", 128'(bus.ser_valid_o), 128'(1));
            chk("stall_data", 128'(bus.ser_data_o), 128'(vec(id)));
            chk("stall_ready", 128'(bus.req_ready_o), 128'(0));
            cyc();
        end
        bus.ser_ready_i = 1'b1;
        #1;
        chk("load_data", 128'(bus.ser_data_o), 128'(vec(id)));
        chk("load_req_ready", 128'(bus.req_ready_o), 128'(1 << id));
        chk("load_busy", 128'(bus.busy_o), 128'(1));
        cyc();
        n = 0;
        guard = 0;
        while (n < LH && guard < 40) begin
            y = gappy ? pat[guard % 8] : 1'b1;
            bus.ser_yumi_i = y;
            #1;
            chk("drain_src_id", 128'(bus.src_id_o), 128'(id));
            chk("drain_src_valid", 128'(bus.src_id_valid_o), 128'(1));
            chk("drain_req_ready", 128'(bus.req_ready_o), 128'(0));
            chk("drain_ser_valid", 128'(bus.ser_valid_o), 128'(0));
            if (y) n++;
            cyc();
            guard++;
        end
        bus.ser_yumi_i = 1'b0;
        chk("yumi_count", 128'(n), 128'(LH));
        chk("drain_cycles", 128'(guard), gappy ? 128'(8) : 128'(LH));
        chk("idle_busy", 128'(bus.busy_o), 128'(0));
        chk("idle_src_valid", 128'(bus.src_id_valid_o), 128'(0));
        chk("idle_req_ready", 128'(bus.req_ready_o), 128'(0));
        $display("burst: src_id=%0d yumi=%0d drain_cycles=%0d stall=%0d", id, n, guard, stall);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        bus.req_valid_i = '0;
        bus.ser_ready_i = 1'b1;
        bus.ser_yumi_i  = 1'b0;
        for (int r = 0; r < NR; r++) bus.req_data_i[r] = vec(r);
        cyc();
        cyc();
        bus.req_valid_i = 4'b1111;
        #1;
        chk("reset_outputs", all_outs, 128'(0));
        rst             = 1'b0;
        bus.req_valid_i = '0;
        cyc();
        chk("idle_after_reset", all_outs, 128'(0));

        // Single requester 0
        bus.req_valid_i = 4'b0001;
        exp_q.push_back(0);
        serve_burst(0, 1'b0);

        // All requesters: rotation 0,1,2,3,0 from a fresh pointer
        bus.req_valid_i = '0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.req_valid_i = 4'b1111;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0);
        for (int b = 0; b < 5; b++) serve_burst(0, 1'b0);

        // Set pointer to 3, then 3 and 1 competing: 1,3,1
        bus.req_valid_i = 4'b1000;
        exp_q.push_back(3);
        serve_burst(0, 1'b0);
        bus.req_valid_i = 4'b1010;
        exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(1);
        for (int b = 0; b < 3; b++) serve_burst(0, 1'b0);

        // Serializer back-pressure in LOAD
        bus.req_valid_i = 4'b0001;
        exp_q.push_back(0);
        serve_burst(3, 1'b0);

        // Gapped yumi during drain
        bus.req_valid_i = 4'b0010;
        exp_q.push_back(1);
        serve_burst(0, 1'b1);

        // Reset after 2 of 5 yumi aborts the burst and restores the pointer
        bus.req_valid_i = 4'b0100;
        cyc();
        chk("abort_load_data", 128'(bus.ser_data_o), 128'(vec(2)));
        cyc();
        chk("abort_src_id", 128'(bus.src_id_o), 128'(2));
        bus.ser_yumi_i = 1'b1;
        cyc();
        cyc();
        bus.ser_yumi_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("during_mid_reset", all_outs, 128'(0));
        cyc();
        bus.req_valid_i = '0;
        rst = 1'b0;
        #1;
        chk("after_mid_reset", all_outs, 128'(0));
        $display("abort: reset applied after 2 yumi of src_id=2");
        bus.req_valid_i = 4'b1111;
        exp_q.push_back(0);
        serve_burst(0, 1'b0);
        bus.req_valid_i = '0;

        chk("sb_drained", 128'(exp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
